// File: rtl/nvram_restore_if.sv
// ioctl download channel plus game-RAM write port and CPU pause handshake
// shared between the platform bridge and the NVRAM restore block.
interface nvram_restore_if #(
   parameter int DUMPWIDTH = 8
);
   logic                 core_reset;
   logic                 paused;
   logic                 ioctl_download;
   logic                 ioctl_wr;
   logic [24:0]          ioctl_addr;
   logic [7:0]           ioctl_index;
   logic [7:0]           ioctl_dout;
   logic [DUMPWIDTH-1:0] nvram_address;
   logic [7:0]           nvram_data_in;
   logic                 nvram_we;
   logic                 pause_cpu;
   logic                 restore_done;

   modport slave (
      input  core_reset, paused, ioctl_download, ioctl_wr, ioctl_addr, ioctl_index, ioctl_dout,
      output nvram_address, nvram_data_in, nvram_we, pause_cpu, restore_done
   );

   modport master (
      output core_reset, paused, ioctl_download, ioctl_wr, ioctl_addr, ioctl_index, ioctl_dout,
      input  nvram_address, nvram_data_in, nvram_we, pause_cpu, restore_done
   );
endinterface

// File: rtl/nvram_restore.sv
// Buffers an NVRAM/hiscore dump from the ioctl channel and, after core reset
// release plus a hold-off, pauses the CPU and replays the bytes into game RAM.
module nvram_restore #(
   parameter int          DUMPWIDTH    = 8,
   parameter logic [7:0]  DUMPINDEX    = 8'd3,
   parameter int unsigned PAUSEPAD     = 4,
   parameter logic [31:0] RESTOREDELAY = 32'd1024
) (
   input  logic            clk,
   input  logic            reset_n,
   nvram_restore_if.slave  bus
);
   localparam int DEPTH = 1 << DUMPWIDTH;
   localparam logic [DUMPWIDTH:0]   LEN_ONE = 1;
   localparam logic [DUMPWIDTH-1:0] IDX_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_HOLDOFF, S_PAUSE_PRE, S_READ, S_WRITE, S_PAUSE_POST, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          timer_q, timer_d;
   logic [DUMPWIDTH-1:0] idx_q, idx_d;
   logic [DUMPWIDTH:0]   dump_length_q, dump_length_d;
   logic                 dump_valid_q, dump_valid_d;
   logic                 pending_q, pending_d;
   logic                 dl_act_q, core_reset_q;
   logic [7:0]           buf_mem [DEPTH];
   logic [7:0]           rd_q;

   logic                 dl_act, dl_start, dl_end, cr_fall, cap_wr;
   logic [DUMPWIDTH:0]   wr_len;

   assign dl_act   = bus.ioctl_download && (bus.ioctl_index == DUMPINDEX);
   assign dl_start = dl_act & ~dl_act_q;
   assign dl_end   = dl_act_q & ~bus.ioctl_download;
   assign cr_fall  = core_reset_q & ~bus.core_reset;
   // Bytes beyond the buffer window are dropped rather than aliased.
   assign cap_wr   = dl_act && bus.ioctl_wr && (bus.ioctl_addr[24:DUMPWIDTH] == '0);
   assign wr_len   = {1'b0, bus.ioctl_addr[DUMPWIDTH-1:0]} + LEN_ONE;

   always_ff @(posedge clk) begin
      if (cap_wr) buf_mem[bus.ioctl_addr[DUMPWIDTH-1:0]] <= bus.ioctl_dout;
      rd_q <= buf_mem[idx_q];
   end

   always_comb begin
      dump_length_d = dl_start ? '0 : dump_length_q;
      dump_valid_d  = dump_valid_q;
      pending_d     = pending_q;
      if (cap_wr && (wr_len > dump_length_d)) dump_length_d = wr_len;
      if (dl_start) begin
         dump_valid_d = 1'b0;
         pending_d    = 1'b0;
      end
      if (dl_end && (dump_length_q != '0)) begin
         dump_valid_d = 1'b1;
         pending_d    = 1'b1;
      end
      // A core reset wipes game RAM, so a held dump must be replayed.
      if (cr_fall && dump_valid_q) pending_d = 1'b1;
      if (state_q == S_DONE) pending_d = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE:
            if (pending_q && !bus.core_reset && !dl_act) begin
               timer_d = RESTOREDELAY;
               state_d = S_HOLDOFF;
            end
         S_HOLDOFF:
            if (timer_q == '0) begin
               timer_d = PAUSEPAD;
               state_d = S_PAUSE_PRE;
            end else timer_d = timer_q - 32'd1;
         S_PAUSE_PRE:
            if (timer_q == '0) begin
               idx_d   = '0;
               state_d = S_READ;
            end else if (bus.paused) timer_d = timer_q - 32'd1;
         S_READ:  state_d = S_WRITE;
         S_WRITE:
            if ({1'b0, idx_q} == (dump_length_q - LEN_ONE)) begin
               timer_d = PAUSEPAD;
               state_d = S_PAUSE_POST;
            end else begin
               idx_d   = idx_q + IDX_ONE;
               state_d = S_READ;
            end
         S_PAUSE_POST:
            if (timer_q == '0) state_d = S_DONE;
            else timer_d = timer_q - 32'd1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if ((state_q != S_IDLE) && (bus.core_reset || dl_start)) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         idx_q         <= '0;
         dump_length_q <= '0;
         dump_valid_q  <= 1'b0;
         pending_q     <= 1'b0;
         dl_act_q      <= 1'b0;
         core_reset_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         idx_q         <= idx_d;
         dump_length_q <= dump_length_d;
         dump_valid_q  <= dump_valid_d;
         pending_q     <= pending_d;
         dl_act_q      <= dl_act;
         core_reset_q  <= bus.core_reset;
      end
   end

   assign bus.pause_cpu     = (state_q == S_PAUSE_PRE) || (state_q == S_READ) ||
                              (state_q == S_WRITE) || (state_q == S_PAUSE_POST);
   assign bus.nvram_we      = (state_q == S_WRITE);
   assign bus.nvram_address = (state_q == S_WRITE) ? idx_q : '0;
   assign bus.nvram_data_in = (state_q == S_WRITE) ? rd_q : 8'h00;
   assign bus.restore_done  = (state_q == S_DONE);
endmodule

// File: tb/tb_nvram_restore.sv
// Directed bench for nvram_restore: table of dump downloads plus hand-written
// sequences for core-reset abort, re-arm and asynchronous reset.
module tb_nvram_restore;
   localparam int DW = 8;

   typedef struct {
      logic [7:0] idx;
      int         n;
      logic [7:0] d0;
      bit         oob;
      int         exp_wr;
      int         exp_done;
      int         budget;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   nvram_restore_if #(.DUMPWIDTH(DW)) bus ();

   nvram_restore #(
      .DUMPWIDTH(DW), .DUMPINDEX(8'd3), .PAUSEPAD(4), .RESTOREDELAY(32'd8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) bus.paused <= 1'b0;
      else          bus.paused <= bus.pause_cpu;

   int vecs = 0;
   int errs = 0;
   int nwr, ndone, pr, pf, dc, bad_pause;
   int w_addr [600];
   int w_data [600];
   int w_cyc  [600];
   vec_t tv [4];

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      vecs++;
      if (act < lo || act > hi) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic download(input logic [7:0] idx, input int n, input logic [7:0] d0, input bit oob);
      @(negedge clk);
      bus.ioctl_download = 1'b1;
      bus.ioctl_index    = idx;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.ioctl_addr = 25'(i);
         bus.ioctl_dout = d0 + 8'(i);
         bus.ioctl_wr   = 1'b1;
         @(negedge clk);
         bus.ioctl_wr   = 1'b0;
         if (oob && i == 1) begin
            @(negedge clk);
            bus.ioctl_addr = 25'h100;
            bus.ioctl_dout = 8'hEE;
            bus.ioctl_wr   = 1'b1;
            @(negedge clk);
            bus.ioctl_wr   = 1'b0;
         end
      end
      @(negedge clk);
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      bus.ioctl_index = 8'd0;
   endtask

   task automatic pulse_core_reset();
      @(negedge clk);
      bus.core_reset = 1'b1;
      @(negedge clk);
      bus.core_reset = 1'b0;
   endtask

   // Watches outputs on falling edges; optionally forces core_reset after N writes.
   task automatic observe(input int budget, input int abort_after);
      logic prev_pause;
      nwr = 0; ndone = 0; pr = -1; pf = -1; dc = -1; bad_pause = 0;
      prev_pause = bus.pause_cpu;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (bus.pause_cpu && !prev_pause && pr < 0) pr = c;
         if (!bus.pause_cpu && prev_pause) pf = c;
         prev_pause = bus.pause_cpu;
         if (bus.restore_done) begin
            ndone++;
            dc = c;
         end
         if (bus.nvram_we && nwr < 600) begin
            if (!bus.pause_cpu) bad_pause++;
            w_addr[nwr] = int'(bus.nvram_address);
            w_data[nwr] = int'(bus.nvram_data_in);
            w_cyc[nwr]  = c;
            nwr++;
            if (abort_after != 0 && nwr == abort_after) begin
               bus.core_reset = 1'b1;
               @(negedge clk);
               chk("abort_we", int'(bus.nvram_we), 0);
               chk("abort_pause", int'(bus.pause_cpu), 0);
               bus.core_reset = 1'b0;
               return;
            end
         end
      end
   endtask

   task automatic check_restore(input string name, input int n, input logic [7:0] d0);
      int bad_ad, bad_gap;
      logic [7:0] e;
      bad_ad = 0; bad_gap = 0;
      chk({name, "_writes"}, nwr, n);
      chk({name, "_done"}, ndone, 1);
      chk({name, "_we_unpaused"}, bad_pause, 0);
      if (nwr > 0) begin
         for (int i = 0; i < nwr; i++) begin
            e = d0 + 8'(i);
            if (w_addr[i] != i || w_data[i] != int'(e)) bad_ad++;
            if (i > 0 && (w_cyc[i] - w_cyc[i-1]) != 2) bad_gap++;
         end
         chk({name, "_addr_data_bad"}, bad_ad, 0);
         chk({name, "_gap_bad"}, bad_gap, 0);
         chk({name, "_last_addr"}, w_addr[nwr-1], n - 1);
         chk_rng({name, "_holdoff"}, pr, 8, 14);
         chk_rng({name, "_pre_pad"}, w_cyc[0] - pr, 5, 8);
         chk_rng({name, "_post_pad"}, pf - w_cyc[nwr-1], 4, 6);
         chk({name, "_done_at_unpause"}, dc, pf);
      end
   endtask

   initial begin
      int found;
      bus.core_reset = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr = 1'b0;
      bus.ioctl_addr = '0;
      bus.ioctl_index = 8'd0;
      bus.ioctl_dout = 8'd0;

      tv[0] = '{8'd3, 256, 8'h00, 1'b0, 256, 1, 700};
      tv[1] = '{8'd3,   4, 8'hA0, 1'b1,   4, 1, 120};
      tv[2] = '{8'd3,  16, 8'h10, 1'b0,  16, 1, 120};
      tv[3] = '{8'd2,  16, 8'h50, 1'b0,   0, 0, 120};

      #1;
      chk("rst_we", int'(bus.nvram_we), 0);
      chk("rst_pause", int'(bus.pause_cpu), 0);
      chk("rst_done", int'(bus.restore_done), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         download(tv[v].idx, tv[v].n, tv[v].d0, tv[v].oob);
         observe(tv[v].budget, 0);
         if (tv[v].exp_done != 0) check_restore($sformatf("vec%0d", v), tv[v].exp_wr, tv[v].d0);
         else begin
            chk($sformatf("vec%0d_writes", v), nwr, tv[v].exp_wr);
            chk($sformatf("vec%0d_done", v), ndone, 0);
            chk($sformatf("vec%0d_pause", v), pr, -1);
         end
      end

      // Re-arm from core reset replays the index-3 dump untouched by the index-2 one.
      pulse_core_reset();
      observe(120, 0);
      check_restore("rearm", 16, 8'h10);

      pulse_core_reset();
      observe(120, 6);
      chk("abort_count", nwr, 6);
      observe(120, 0);
      check_restore("rerun", 16, 8'h10);

      pulse_core_reset();
      found = 0;
      for (int c = 0; c < 200 && found == 0; c++) begin
         @(negedge clk);
         if (bus.nvram_we) found = 1;
      end
      chk("wait_write", found, 1);
      reset_n = 1'b0;
      #1;
      chk("areset_we", int'(bus.nvram_we), 0);
      chk("areset_pause", int'(bus.pause_cpu), 0);
      chk("areset_done", int'(bus.restore_done), 0);
      chk("areset_addr", int'(bus.nvram_address), 0);
      chk("areset_data", int'(bus.nvram_data_in), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      pulse_core_reset();
      pulse_core_reset();
      observe(150, 0);
      chk("post_rst_writes", nwr, 0);
      chk("post_rst_done", ndone, 0);
      chk("post_rst_pause", pr, -1);

      download(8'd3, 16, 8'h30, 1'b0);
      observe(120, 0);
      check_restore("post_rst_dl", 16, 8'h30);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
